reel_spin_sequencer: RTL and testbench

Frame-paced spin sequencer for a parametrised number of slot-machine reels. It captures per-reel final sprite IDs on a spin request and drives each reel's vertical scroll offset once per video frame: fast phase, then slow phase, then stop exactly on the target sprite, with reels stopping strictly left to right. It sits between the command source (SPI extract or tie-offs) and the pixel/memory path, which reads `reel_offset` to fetch sprite rows.

---
 rtl/slot_pkg.sv | 25 ++
 rtl/reel_spin_sequencer_if.sv | 25 ++
 rtl/reel_channel.sv | 66 ++++++
 rtl/reel_spin_sequencer.sv | 96 +++++++++
 tb/tb_reel_spin_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and geometry helpers for the reel spin sequencer.
// Pure definitions; no logic, no latency.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_DONE = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    PH_FAST    = 2'd0,
    PH_SLOW    = 2'd1,
    PH_STOPPED = 2'd2
  } reel_phase_t;

  function automatic int strip_len(input int num_sprites, input int sprite_h);
    return num_sprites * sprite_h;
  endfunction

  function automatic int off_width(input int num_sprites, input int sprite_h);
    return $clog2(num_sprites * sprite_h);
  endfunction

endpackage

// File: rtl/reel_spin_sequencer_if.sv
// Command/status bundle between the command source and the sequencer.
// Level signals only; no handshake, the sequencer never stalls the source.
interface reel_spin_sequencer_if #(
  parameter int NUM_REELS = 3,
  parameter int SPRITE_W  = 3,
  parameter int OFF_W     = 9
);
  logic                          start_spin;
  logic [NUM_REELS*SPRITE_W-1:0] final_sprite;
  logic [NUM_REELS*OFF_W-1:0]    reel_offset;
  logic [NUM_REELS-1:0]          reel_stopped;
  logic                          busy;
  logic                          done;
  logic [2:0]                    state_led;

  modport master (
    output start_spin, final_sprite,
    input  reel_offset, reel_stopped, busy, done, state_led
  );

  modport slave (
    input  start_spin, final_sprite,
    output reel_offset, reel_stopped, busy, done, state_led
  );
endinterface

// File: rtl/reel_channel.sv
// One reel: fast phase, slow phase, then stop on target once the left reel is at rest.
// Offset/stopped update on the edge after a tick; no backpressure.
module reel_channel
  import slot_pkg::*;
#(
  parameter int STRIP     = 512,
  parameter int OFF_W     = 9,
  parameter int FAST_STEP = 16,
  parameter int SLOW_STEP = 4,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start,
  input  logic [CNT_W-1:0] fast_frames,
  input  logic [OFF_W-1:0] target,
  input  logic             left_stopped,
  output logic [OFF_W-1:0] offset,
  output logic             stopped
);

  reel_phase_t      phase;
  logic [CNT_W-1:0] cnt;

  // One extra bit keeps the carry so a non-power-of-two strip still wraps exactly.
  function automatic logic [OFF_W-1:0] wrap_add(input logic [OFF_W-1:0] a, input int step);
    logic [OFF_W:0] s;
    s = {1'b0, a} + (OFF_W+1)'(step);
    if (s >= (OFF_W+1)'(STRIP))
      s = s - (OFF_W+1)'(STRIP);
    return s[OFF_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset  <= '0;
      cnt     <= '0;
      phase   <= PH_STOPPED;
      stopped <= 1'b1;
    end else if (start) begin
      cnt     <= '0;
      phase   <= PH_FAST;
      stopped <= 1'b0;
    end else if (tick) begin
      case (phase)
        PH_FAST: begin
          offset <= wrap_add(offset, FAST_STEP);
          cnt    <= cnt + 1'b1;
          if (cnt == fast_frames - 1'b1)
            phase <= PH_SLOW;
        end
        PH_SLOW: begin
          if (offset == target && left_stopped) begin
            phase   <= PH_STOPPED;
            stopped <= 1'b1;
          end else begin
            offset <= wrap_add(offset, SLOW_STEP);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reel_spin_sequencer.sv
// Frame-paced multi-reel spin sequencer: start edge -> SPIN next cycle, offsets move one cycle after each vsync tick.
// All outputs registered; start edges during SPIN are dropped, no backpressure.
module reel_spin_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_REELS      = 3,
  parameter int NUM_SPRITES    = 8,
  parameter int SPRITE_W       = 3,
  parameter int SPRITE_H       = 64,
  parameter int FAST_STEP      = 16,
  parameter int SLOW_STEP      = 4,
  parameter int SPIN_FRAMES    = 60,
  parameter int STAGGER_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vsync,
  reel_spin_sequencer_if.slave bus
);

  localparam int STRIP    = strip_len(NUM_SPRITES, SPRITE_H);
  localparam int OFF_W    = off_width(NUM_SPRITES, SPRITE_H);
  localparam int MAX_FAST = SPIN_FRAMES + (NUM_REELS - 1) * STAGGER_FRAMES;
  localparam int CNT_W    = $clog2(MAX_FAST + 1);

  top_state_t           state;
  logic                 start_q;
  logic                 vsync_q;
  logic                 spin_go;
  logic                 tick;
  logic [NUM_REELS-1:0] stopped;
  logic [OFF_W-1:0]     tgt [NUM_REELS];

  // A start that launches a spin swallows a coincident frame tick.
  assign spin_go = bus.start_spin && !start_q && (state != ST_SPIN);
  assign tick    = !vsync && vsync_q && !spin_go;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      start_q       <= 1'b1;
      vsync_q       <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.state_led <= 3'b001;
      for (int i = 0; i < NUM_REELS; i++)
        tgt[i] <= '0;
    end else begin
      start_q <= bus.start_spin;
      vsync_q <= vsync;
      if (spin_go) begin
        state         <= ST_SPIN;
        bus.busy      <= 1'b1;
        bus.done      <= 1'b0;
        bus.state_led <= 3'b010;
        for (int i = 0; i < NUM_REELS; i++)
          tgt[i] <= OFF_W'(bus.final_sprite[i*SPRITE_W +: SPRITE_W]) * OFF_W'(SPRITE_H);
      end else if (state == ST_SPIN && (&stopped)) begin
        state         <= ST_DONE;
        bus.busy      <= 1'b0;
        bus.done      <= 1'b1;
        bus.state_led <= 3'b100;
      end
    end
  end

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    logic left_stopped;
    if (g == 0) begin : g_first
      assign left_stopped = 1'b1;
    end else begin : g_rest
      assign left_stopped = stopped[g-1];
    end

    reel_channel #(
      .STRIP     (STRIP),
      .OFF_W     (OFF_W),
      .FAST_STEP (FAST_STEP),
      .SLOW_STEP (SLOW_STEP),
      .CNT_W     (CNT_W)
    ) u_reel (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick         (tick),
      .start        (spin_go),
      .fast_frames  (CNT_W'(SPIN_FRAMES + g * STAGGER_FRAMES)),
      .target       (tgt[g]),
      .left_stopped (left_stopped),
      .offset       (bus.reel_offset[g*OFF_W +: OFF_W]),
      .stopped      (stopped[g])
    );
  end

  assign bus.reel_stopped = stopped;

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Randomised bench for reel_spin_sequencer against a closed-form per-tick offset model.
module tb_reel_spin_sequencer;
  import slot_pkg::*;

  localparam int NR    = 3;
  localparam int NS    = 8;
  localparam int SW    = 3;
  localparam int SH    = 64;
  localparam int FS    = 16;
  localparam int SS    = 4;
  localparam int SF    = 60;
  localparam int STG   = 30;
  localparam int STRIP = NS * SH;
  localparam int OW    = $clog2(STRIP);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic vsync   = 1'b1;

  reel_spin_sequencer_if #(.NUM_REELS(NR), .SPRITE_W(SW), .OFF_W(OW)) bus ();

  reel_spin_sequencer #(
    .NUM_REELS(NR), .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
    .FAST_STEP(FS), .SLOW_STEP(SS), .SPIN_FRAMES(SF), .STAGGER_FRAMES(STG)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: spin-start offsets, targets, offset at end of fast phase, stop tick per reel.
  int m_off  [NR];
  int m_tgt  [NR];
  int m_base [NR];
  int m_stop [NR];

  function automatic int fast_n(input int i);
    return SF + i * STG;
  endfunction

  task automatic plan(input int sp [NR]);
    for (int i = 0; i < NR; i++) begin
      int f;
      f         = fast_n(i);
      m_tgt[i]  = sp[i] * SH;
      m_base[i] = (m_off[i] + FS * f) % STRIP;
      m_stop[i] = 0;
      for (int t = f + 1; t < f + 1 + (i + 2) * STRIP / SS && m_stop[i] == 0; t++)
        if (((m_base[i] + SS * (t - 1 - f)) % STRIP) == m_tgt[i] && (i == 0 || t > m_stop[i-1]))
          m_stop[i] = t;
    end
  endtask

  function automatic int exp_off(input int i, input int n);
    int f;
    f = fast_n(i);
    if (n <= f)           return (m_off[i] + FS * n) % STRIP;
    else if (n < m_stop[i]) return (m_base[i] + SS * (n - f)) % STRIP;
    else                  return m_tgt[i];
  endfunction

  task automatic do_tick();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < NR; i++)
      chk({tag, "_off"}, 32'(bus.reel_offset[i*OW +: OW]), 0);
    chk({tag, "_stopped"}, 32'(bus.reel_stopped), 32'h7);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_done"},    32'(bus.done), 0);
    chk({tag, "_led"},     32'(bus.state_led), 32'h1);
  endtask

  task automatic run_spin(input int sp [NR], input bit coincide, input int mid_start,
                          input int abort_at, output int obs_stop [NR], output int off0_60);
    int last;
    plan(sp);
    last = 0;
    for (int i = 0; i < NR; i++) begin
      obs_stop[i] = 0;
      if (m_stop[i] > last) last = m_stop[i];
    end
    off0_60 = -1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) bus.final_sprite[i*SW +: SW] = SW'(sp[i]);
    bus.start_spin = 1'b1;
    if (coincide) vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    chk("busy_on",  32'(bus.busy), 1);
    chk("done_clr", 32'(bus.done), 0);
    chk("led_spin", 32'(bus.state_led), 32'h2);
    @(negedge clk);
    bus.start_spin = 1'b0;
    for (int i = 0; i < NR; i++)
      chk("start_off", 32'(bus.reel_offset[i*OW +: OW]), 32'(m_off[i]));
    chk("start_stopped", 32'(bus.reel_stopped), 0);

    for (int n = 1; n <= last; n++) begin
      if (n == mid_start) begin
        @(negedge clk) bus.start_spin = 1'b1;
        @(negedge clk) bus.start_spin = 1'b0;
        @(negedge clk);
      end
      do_tick();
      if (n == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < NR; i++) m_off[i] = 0;
        return;
      end
      for (int i = 0; i < NR; i++) begin
        chk("off", 32'(bus.reel_offset[i*OW +: OW]), 32'(exp_off(i, n)));
        chk("stopped", 32'(bus.reel_stopped[i]), (n >= m_stop[i]) ? 32'd1 : 32'd0);
        if (bus.reel_stopped[i] && obs_stop[i] == 0) obs_stop[i] = n;
      end
      if (n == SF) off0_60 = int'(bus.reel_offset[OW-1:0]);
      if (n < last) chk("busy_mid", 32'(bus.busy), 1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("done_end", 32'(bus.done), 1);
    chk("busy_end", 32'(bus.busy), 0);
    chk("led_done", 32'(bus.state_led), 32'h4);
    for (int i = 0; i < NR; i++) chk("stop_tick", 32'(obs_stop[i]), 32'(m_stop[i]));
    for (int i = 1; i < NR; i++) chk("stop_order", 32'(obs_stop[i] > obs_stop[i-1]), 1);
    for (int i = 0; i < NR; i++) m_off[i] = m_tgt[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sp [NR];
    int os [NR];
    int o60;
    bus.start_spin   = 1'b1;
    bus.final_sprite = '0;
    for (int i = 0; i < NR; i++) m_off[i] = 0;

    // start held high through reset must not launch a spin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    do_tick();
    check_reset_vals("hold");
    bus.start_spin = 1'b0;
    repeat (2) @(negedge clk);

    // defaults from offset 0, start coinciding with a vsync fall
    sp = '{2, 2, 2};
    run_spin(sp, 1'b1, -1, -1, os, o60);
    chk("r0_at60", 32'(o60), 448);
    chk("r0_stop109", 32'(os[0]), 109);

    // restart from DONE with a stray start edge mid-spin
    for (int i = 0; i < NR; i++) sp[i] = int'($urandom_range(0, NS - 1));
    run_spin(sp, 1'b0, 40, -1, os, o60);

    // reset in the middle of a spin
    for (int i = 0; i < NR; i++) sp[i] = int'($urandom_range(0, NS - 1));
    run_spin(sp, 1'b0, -1, 50, os, o60);
    repeat (2) @(negedge clk);

    // reel 1 hits its target before reel 0 rests and must lap
    sp = '{2, 7, 0};
    run_spin(sp, 1'b0, -1, -1, os, o60);
    chk("r1_lap_stop", 32'(os[1]), 227);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) sp[i] = int'($urandom_range(0, NS - 1));
      run_spin(sp, 1'b0, -1, -1, os, o60);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
